// File: rtl/fir_pkg.sv
`default_nettype none
//==========================================================================
// fir_pkg : shared state encoding and width helper for the FIR sequencer
// Rev 1.0
//==========================================================================
package fir_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      MAC     = 3'd2,
      DRAIN   = 3'd3,
      DATAOUT = 3'd4
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fir_addr_gen.sv
`default_nettype none
//==========================================================================
// fir_addr_gen : write pointer, tap counter and delay-line/coef addressing
// Rev 1.0
//==========================================================================
module fir_addr_gen
   import fir_pkg::*;
#(
   parameter  int NTAPS  = 16,
   parameter  int NCH    = 2,
   localparam int TAP_W  = clog2(NTAPS),
   localparam int CH_W   = (clog2(NCH) > 1) ? clog2(NCH) : 1,
   localparam int ADDR_W = clog2(NCH * NTAPS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CH_W-1:0]   ch,
   input  logic              start,
   input  logic              step,
   input  logic              advance,
   output logic [TAP_W-1:0]  coef_addr,
   output logic [ADDR_W-1:0] data_addr,
   output logic              last
);

   localparam logic [TAP_W-1:0] c_last_tap = TAP_W'(NTAPS - 1);

   logic [TAP_W-1:0]  r_wptr;
   logic [TAP_W-1:0]  r_k;
   logic [TAP_W-1:0]  w_off;
   logic [ADDR_W-1:0] w_base;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [ADDR_W-1:0] w_tap_addr;

   // Offset wraps inside the channel segment so it never carries into the next one.
   always_comb begin
      w_base     = ADDR_W'(int'(ch) * NTAPS);
      w_off      = (r_wptr >= r_k) ? (r_wptr - r_k)
                                   : TAP_W'(int'(r_wptr) + NTAPS - int'(r_k));
      w_wr_addr  = w_base + ADDR_W'(r_wptr);
      w_tap_addr = w_base + ADDR_W'(w_off);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr    <= '0;
         r_k       <= '0;
         coef_addr <= '0;
         data_addr <= '0;
      end else begin
         if (start) begin
            data_addr <= w_wr_addr;
            r_k       <= '0;
         end else if (step) begin
            coef_addr <= r_k;
            data_addr <= w_tap_addr;
            r_k       <= (r_k == c_last_tap) ? '0 : r_k + 1'b1;
         end
         if (advance)
            r_wptr <= (r_wptr == c_last_tap) ? '0 : r_wptr + 1'b1;
      end
   end

   assign last = (coef_addr == c_last_tap);

endmodule
`default_nettype wire

// File: rtl/fir_sequencer.sv
`default_nettype none
//==========================================================================
// fir_sequencer : multi-channel control sequencer for a time-multiplexed MAC FIR
// Rev 1.0
//==========================================================================
module fir_sequencer
   import fir_pkg::*;
#(
   parameter  int NTAPS   = 16,
   parameter  int NCH     = 2,
   parameter  int MAC_LAT = 2,
   localparam int TAP_W   = clog2(NTAPS),
   localparam int CH_W    = (clog2(NCH) > 1) ? clog2(NCH) : 1,
   localparam int ADDR_W  = clog2(NCH * NTAPS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample,
   output logic              busy,
   output logic [CH_W-1:0]   ch,
   output logic              wr_en,
   output logic              clr,
   output logic              mac_en,
   output logic [TAP_W-1:0]  coef_addr,
   output logic [ADDR_W-1:0] data_addr,
   output logic              oe,
   output logic              overrun
);

   localparam int              LAT_W      = (clog2(MAC_LAT + 1) > 1) ? clog2(MAC_LAT + 1) : 1;
   localparam logic [CH_W-1:0]  c_last_ch  = CH_W'(NCH - 1);
   localparam logic [LAT_W-1:0] c_lat_end  = LAT_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

   state_t            r_state;
   logic [CH_W-1:0]   r_ch;
   logic [LAT_W-1:0]  r_lat;
   logic              w_last;
   logic              w_start;
   logic              w_step;
   logic              w_advance;
   logic [CH_W-1:0]   w_ch_sel;

   // Address generator loads on the edge entering each state, so it sees the next channel.
   always_comb begin
      w_start   = ((r_state == IDLE) && sample) ||
                  ((r_state == DATAOUT) && (r_ch != c_last_ch));
      w_step    = (r_state == WRITE) || ((r_state == MAC) && !w_last);
      w_advance = (r_state == DATAOUT) && (r_ch == c_last_ch);
      w_ch_sel  = r_ch;
      if (r_state == DATAOUT)
         w_ch_sel = r_ch + 1'b1;
      else if (r_state == IDLE)
         w_ch_sel = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_ch    <= '0;
         r_lat   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (sample) begin
                  r_state <= WRITE;
                  r_ch    <= '0;
               end
            end
            WRITE:   r_state <= MAC;
            MAC: begin
               if (w_last) begin
                  r_lat   <= '0;
                  r_state <= (MAC_LAT > 0) ? DRAIN : DATAOUT;
               end
            end
            DRAIN: begin
               if (r_lat == c_lat_end)
                  r_state <= DATAOUT;
               else
                  r_lat <= r_lat + 1'b1;
            end
            DATAOUT: begin
               if (r_ch != c_last_ch) begin
                  r_ch    <= r_ch + 1'b1;
                  r_state <= WRITE;
               end else begin
                  r_ch    <= '0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   fir_addr_gen #(
      .NTAPS (NTAPS),
      .NCH   (NCH)
   ) u_addr_gen (
      .clk       (clk),
      .reset     (reset),
      .ch        (w_ch_sel),
      .start     (w_start),
      .step      (w_step),
      .advance   (w_advance),
      .coef_addr (coef_addr),
      .data_addr (data_addr),
      .last      (w_last)
   );

   assign busy    = (r_state != IDLE);
   assign ch      = r_ch;
   assign wr_en   = (r_state == WRITE);
   assign clr     = (r_state == WRITE);
   assign mac_en  = (r_state == MAC);
   assign oe      = (r_state == DATAOUT);
   assign overrun = sample & busy;

endmodule
`default_nettype wire

// File: tb/tb_fir_sequencer.sv
`default_nettype none
//==========================================================================
// tb_fir_sequencer : randomized bench with a per-sample-set trace model
// Rev 1.0
//==========================================================================
module tb_fir_sequencer;
   import fir_pkg::*;

   typedef struct {
      bit busy; int ch; bit wr; bit mac; bit oe;
      int coef; int addr; bit ck_c; bit ck_a;
   } rec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n [3];
   logic smp   [3];

   logic       b0, wr0, clr0, mac0, oe0, ov0;
   logic [0:0] ch0;  logic [1:0] coef0; logic [2:0] addr0;
   logic       b1, wr1, clr1, mac1, oe1, ov1;
   logic [0:0] ch1;  logic [0:0] coef1; logic [0:0] addr1;
   logic       b2, wr2, clr2, mac2, oe2, ov2;
   logic [1:0] ch2;  logic [2:0] coef2; logic [3:0] addr2;

   int n_tests = 0;
   int n_fail  = 0;
   int nt  [3] = '{4, 2, 5};
   int nch [3] = '{2, 1, 3};
   int lat [3] = '{2, 0, 2};

   rec_t mq [3][$];
   int   m_wptr [3];
   int   m_hc [3];
   int   m_ha [3];
   int   sched [$];
   int   e_noe, e_first, e_last, e_busy, e_ov;

   fir_sequencer #(.NTAPS(4), .NCH(2), .MAC_LAT(2)) u_dut0 (
      .clk(clk), .reset(rst_n[0]), .sample(smp[0]), .busy(b0), .ch(ch0),
      .wr_en(wr0), .clr(clr0), .mac_en(mac0), .coef_addr(coef0),
      .data_addr(addr0), .oe(oe0), .overrun(ov0));

   fir_sequencer #(.NTAPS(2), .NCH(1), .MAC_LAT(0)) u_dut1 (
      .clk(clk), .reset(rst_n[1]), .sample(smp[1]), .busy(b1), .ch(ch1),
      .wr_en(wr1), .clr(clr1), .mac_en(mac1), .coef_addr(coef1),
      .data_addr(addr1), .oe(oe1), .overrun(ov1));

   fir_sequencer #(.NTAPS(5), .NCH(3), .MAC_LAT(2)) u_dut2 (
      .clk(clk), .reset(rst_n[2]), .sample(smp[2]), .busy(b2), .ch(ch2),
      .wr_en(wr2), .clr(clr2), .mac_en(mac2), .coef_addr(coef2),
      .data_addr(addr2), .oe(oe2), .overrun(ov2));

   task automatic get_obs(input int w, output integer busy, output integer ch,
                          output integer wr, output integer clr, output integer mac,
                          output integer oe, output integer coef, output integer addr,
                          output integer ov);
      case (w)
         0: begin busy = b0; ch = ch0; wr = wr0; clr = clr0; mac = mac0;
                  oe = oe0; coef = coef0; addr = addr0; ov = ov0; end
         1: begin busy = b1; ch = ch1; wr = wr1; clr = clr1; mac = mac1;
                  oe = oe1; coef = coef1; addr = addr1; ov = ov1; end
         default: begin busy = b2; ch = ch2; wr = wr2; clr = clr2; mac = mac2;
                  oe = oe2; coef = coef2; addr = addr2; ov = ov2; end
      endcase
   endtask

   task automatic model_reset(input int w);
      mq[w].delete();
      m_wptr[w] = 0;
      m_hc[w]   = 0;
      m_ha[w]   = 0;
   endtask

   // Expected cycle-by-cycle trace of one full sample set, straight from the sequencing rules.
   task automatic build(input int w);
      int n = nt[w];
      int wp = m_wptr[w];
      int a = 0;
      rec_t r;
      for (int c = 0; c < nch[w]; c++) begin
         r = '{1, c, 1, 0, 0, 0, c*n + wp, 0, 1};
         mq[w].push_back(r);
         for (int k = 0; k < n; k++) begin
            a = c*n + ((wp - k + n) % n);
            r = '{1, c, 0, 1, 0, k, a, 1, 1};
            mq[w].push_back(r);
         end
         for (int d = 0; d < lat[w]; d++) begin
            r = '{1, c, 0, 0, 0, n-1, a, 1, 1};
            mq[w].push_back(r);
         end
         r = '{1, c, 0, 0, 1, 0, 0, 0, 0};
         mq[w].push_back(r);
      end
      m_wptr[w] = (wp + 1) % n;
   endtask

   task automatic run_sched(input int w, input int ncyc, input bit drain);
      int sp = 0;
      int i = 0;
      bit s;
      bit q_busy;
      rec_t ex;
      integer busy, ch, wr, clr, mac, oe, coef, addr, ov;
      e_noe = 0; e_first = -1; e_last = -1; e_busy = 0; e_ov = 0;
      while (i < ncyc || (drain && mq[w].size() != 0 && i < ncyc + 500)) begin
         @(negedge clk);
         s = (sp < sched.size()) && (sched[sp] == i);
         if (s) sp++;
         smp[w] = s;
         #1;
         get_obs(w, busy, ch, wr, clr, mac, oe, coef, addr, ov);
         q_busy = (mq[w].size() != 0);
         if (q_busy) ex = mq[w][0];
         else        ex = '{0, 0, 0, 0, 0, m_hc[w], m_ha[w], 1, 1};
         n_tests++;
         if (busy !== ex.busy) begin n_fail++;
            $display("FAIL dut%0d cyc%0d busy: got %0d want %0d", w, i, busy, ex.busy); end
         n_tests++;
         if (wr !== ex.wr) begin n_fail++;
            $display("FAIL dut%0d cyc%0d wr_en: got %0d want %0d", w, i, wr, ex.wr); end
         n_tests++;
         if (clr !== ex.wr) begin n_fail++;
            $display("FAIL dut%0d cyc%0d clr: got %0d want %0d", w, i, clr, ex.wr); end
         n_tests++;
         if (mac !== ex.mac) begin n_fail++;
            $display("FAIL dut%0d cyc%0d mac_en: got %0d want %0d", w, i, mac, ex.mac); end
         n_tests++;
         if (oe !== ex.oe) begin n_fail++;
            $display("FAIL dut%0d cyc%0d oe: got %0d want %0d", w, i, oe, ex.oe); end
         n_tests++;
         if (ch !== ex.ch) begin n_fail++;
            $display("FAIL dut%0d cyc%0d ch: got %0d want %0d", w, i, ch, ex.ch); end
         n_tests++;
         if (ov !== integer'(s && q_busy)) begin n_fail++;
            $display("FAIL dut%0d cyc%0d overrun: got %0d want %0d", w, i, ov, s && q_busy); end
         if (ex.ck_c) begin
            n_tests++;
            if (coef !== ex.coef) begin n_fail++;
               $display("FAIL dut%0d cyc%0d coef_addr: got %0d want %0d", w, i, coef, ex.coef); end
         end
         if (ex.ck_a) begin
            n_tests++;
            if (addr !== ex.addr) begin n_fail++;
               $display("FAIL dut%0d cyc%0d data_addr: got %0d want %0d", w, i, addr, ex.addr); end
         end
         if (busy === 1) e_busy++;
         if (ov === 1) e_ov++;
         if (oe === 1) begin
            e_noe++;
            if (e_first < 0) e_first = i;
            e_last = i;
         end
         if (q_busy) begin
            if (ex.ck_c) begin m_hc[w] = ex.coef; m_ha[w] = ex.addr; end
            void'(mq[w].pop_front());
         end else if (s) begin
            build(w);
         end
         i++;
      end
      smp[w] = 1'b0;
   endtask

   task automatic test_reset;
      integer busy, ch, wr, clr, mac, oe, coef, addr, ov;
      for (int w = 0; w < 3; w++) begin
         rst_n[w] = 1'b0;
         smp[w]   = 1'b0;
         model_reset(w);
      end
      repeat (3) @(negedge clk);
      #1;
      for (int w = 0; w < 3; w++) begin
         get_obs(w, busy, ch, wr, clr, mac, oe, coef, addr, ov);
         n_tests++;
         if ({busy, ch, wr, clr, mac, oe, coef, addr, ov} !== '0) begin n_fail++;
            $display("FAIL reset dut%0d: got busy%0d ch%0d wr%0d clr%0d mac%0d oe%0d coef%0d addr%0d ov%0d want all 0",
                     w, busy, ch, wr, clr, mac, oe, coef, addr, ov); end
      end
      @(negedge clk);
      for (int w = 0; w < 3; w++) rst_n[w] = 1'b1;
   endtask

   task automatic test_single_set;
      sched = '{0};
      run_sched(0, 20, 1);
      n_tests++;
      if (e_busy != 16 || e_noe != 2 || e_first != 8 || e_last != 16) begin n_fail++;
         $display("FAIL single_set: got busy%0d noe%0d oe@%0d,%0d want busy16 noe2 oe@8,16",
                  e_busy, e_noe, e_first, e_last); end
   endtask

   task automatic test_wptr_wrap;
      sched = '{0, 20, 40, 60, 80};
      run_sched(0, 100, 1);
      n_tests++;
      if (e_noe != 10 || e_ov != 0) begin n_fail++;
         $display("FAIL wptr_wrap: got noe%0d ov%0d want noe10 ov0", e_noe, e_ov); end
   endtask

   task automatic test_overrun;
      sched = '{0, 5, 16};
      run_sched(0, 30, 1);
      n_tests++;
      if (e_ov != 2 || e_noe != 2 || e_first != 8 || e_last != 16 || e_busy != 16) begin n_fail++;
         $display("FAIL overrun: got ov%0d noe%0d oe@%0d,%0d busy%0d want ov2 noe2 oe@8,16 busy16",
                  e_ov, e_noe, e_first, e_last, e_busy); end
   endtask

   task automatic test_reset_mid;
      integer busy, ch, wr, clr, mac, oe, coef, addr, ov;
      sched = '{0};
      run_sched(0, 11, 0);
      n_tests++;
      if (mac0 !== 1'b1 || ch0 !== 1'b1) begin n_fail++;
         $display("FAIL reset_mid_pre: got mac%0d ch%0d want mac1 ch1", mac0, ch0); end
      #2 rst_n[0] = 1'b0;
      #1;
      get_obs(0, busy, ch, wr, clr, mac, oe, coef, addr, ov);
      n_tests++;
      if ({busy, ch, wr, clr, mac, oe, coef, addr, ov} !== '0) begin n_fail++;
         $display("FAIL reset_mid_async: got busy%0d ch%0d wr%0d mac%0d oe%0d coef%0d addr%0d want all 0",
                  busy, ch, wr, mac, oe, coef, addr); end
      repeat (2) begin
         @(negedge clk);
         #1;
         n_tests++;
         if (oe0 !== 1'b0 || b0 !== 1'b0) begin n_fail++;
            $display("FAIL reset_mid_hold: got oe%0d busy%0d want 0 0", oe0, b0); end
      end
      @(negedge clk);
      rst_n[0] = 1'b1;
      model_reset(0);
      sched = '{0};
      run_sched(0, 20, 1);
      n_tests++;
      if (e_first != 8 || e_noe != 2) begin n_fail++;
         $display("FAIL reset_mid_restart: got oe@%0d noe%0d want oe@8 noe2", e_first, e_noe); end
   endtask

   task automatic test_small_config;
      sched = '{0, 4, 10};
      run_sched(1, 20, 1);
      n_tests++;
      if (e_busy != 8 || e_noe != 2 || e_first != 4 || e_ov != 1) begin n_fail++;
         $display("FAIL small_config: got busy%0d noe%0d oe@%0d ov%0d want busy8 noe2 oe@4 ov1",
                  e_busy, e_noe, e_first, e_ov); end
   endtask

   task automatic test_three_ch;
      sched = '{0};
      run_sched(2, 35, 1);
      n_tests++;
      if (e_noe != 3 || e_first != 9 || e_last != 27 || e_busy != 27) begin n_fail++;
         $display("FAIL three_ch: got noe%0d oe@%0d..%0d busy%0d want noe3 oe@9..27 busy27",
                  e_noe, e_first, e_last, e_busy); end
   endtask

   task automatic test_random;
      for (int w = 0; w < 3; w++) begin
         sched.delete();
         for (int i = 0; i < 300; i++)
            if ($urandom_range(0, 9) == 0) sched.push_back(i);
         run_sched(w, 300, 1);
      end
   endtask

   initial begin
      test_reset();
      test_single_set();
      test_wptr_wrap();
      test_overrun();
      test_reset_mid();
      test_small_config();
      test_three_ch();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
